// File: rtl/tcam_pkg.sv
// Shared constants and state encoding for the TCAM table loader slice.
package tcam_pkg;
   localparam int TCAM_DEPTH     = 128;
   localparam int TCAM_ADD_DEPTH = 8;
   localparam int DATA_W         = 5;
   localparam int ADD_W          = 2;
   localparam int ADDR_W         = 7;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_CLEAR  = 2'd1;
   localparam state_t ST_STREAM = 2'd2;
   localparam state_t ST_DONE   = 2'd3;
endpackage

// File: rtl/tcam_table_loader_if.sv
// Entry-word stream into the loader: valid/ready handshake carrying target table, index, value and last flag.
interface tcam_table_loader_if;
   import tcam_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sel;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   modport master (
      output in_valid, in_sel, in_addr, in_data, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_sel, in_addr, in_data, in_last,
      output in_ready
   );
endinterface

// File: rtl/tcam_table_mem.sv
// Register-array storage for the data/data_add tables: one write port plus a clear port, full parallel read-out.
// Writes land on the next edge and are visible on the outputs one cycle later; no backpressure.
module tcam_table_mem
   import tcam_pkg::*;
#(
   parameter int DEPTH     = TCAM_DEPTH,
   parameter int ADD_DEPTH = TCAM_ADD_DEPTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clr_en,
   input  logic [ADDR_W-1:0]                clr_idx,
   input  logic                             wr_en,
   input  logic                             wr_sel,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   output logic [DEPTH-1:0][DATA_W-1:0]     data,
   output logic [ADD_DEPTH-1:0][ADD_W-1:0]  data_add
);
   localparam int ADD_IDX_W = (ADD_DEPTH > 1) ? $clog2(ADD_DEPTH) : 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         data     <= '0;
         data_add <= '0;
      end else begin
         if (clr_en) begin
            if (int'(clr_idx) < DEPTH)
               data[clr_idx] <= '0;
            if (int'(clr_idx) < ADD_DEPTH)
               data_add[clr_idx[ADD_IDX_W-1:0]] <= '0;
         end
         // Range guards keep a stray index from aliasing onto a valid entry.
         if (wr_en) begin
            if (!wr_sel) begin
               if (int'(wr_addr) < DEPTH)
                  data[wr_addr] <= wr_data;
            end else if (int'(wr_addr) < ADD_DEPTH) begin
               data_add[wr_addr[ADD_IDX_W-1:0]] <= wr_data[ADD_W-1:0];
            end
         end
      end
   end
endmodule

// File: rtl/tcam_table_loader.sv
// Clear-then-load sequencer for the TCAM data/data_add tables; an accepted entry shows on the outputs one cycle later.
// in_ready is high only while streaming; entries offered during clear are held off.
module tcam_table_loader
   import tcam_pkg::*;
#(
   parameter int DEPTH     = TCAM_DEPTH,
   parameter int ADD_DEPTH = TCAM_ADD_DEPTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   tcam_table_loader_if.slave               in_if,
   output logic [DEPTH-1:0][DATA_W-1:0]     data,
   output logic [ADD_DEPTH-1:0][ADD_W-1:0]  data_add,
   output logic                             write_en,
   output logic                             busy,
   output logic                             err
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              hs;
   logic              add_oor;
   logic              wr_en;

   assign in_if.in_ready = (state == ST_STREAM);
   assign busy           = (state == ST_CLEAR) || (state == ST_STREAM);
   assign hs             = in_if.in_valid & in_if.in_ready;
   assign add_oor        = in_if.in_sel & (int'(in_if.in_addr) >= ADD_DEPTH);
   // An out-of-range data_add entry is still consumed, it just never reaches the tables.
   assign wr_en          = hs & ~add_oor;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         write_en <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_CLEAR;
                  idx      <= '0;
                  write_en <= 1'b0;
                  err      <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (idx == LAST_IDX) begin
                  state <= ST_STREAM;
                  idx   <= '0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            ST_STREAM: begin
               if (hs) begin
                  if (add_oor)
                     err <= 1'b1;
                  if (in_if.in_last) begin
                     state    <= ST_DONE;
                     write_en <= 1'b1;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   tcam_table_mem #(
      .DEPTH     (DEPTH),
      .ADD_DEPTH (ADD_DEPTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .clr_en   (state == ST_CLEAR),
      .clr_idx  (idx),
      .wr_en    (wr_en),
      .wr_sel   (in_if.in_sel),
      .wr_addr  (in_if.in_addr),
      .wr_data  (in_if.in_data),
      .data     (data),
      .data_add (data_add)
   );
endmodule
